// File: rtl/mirfak_wb_arbiter.sv
// -----------------------------------------------------------------------------
// mirfak_wb_arbiter
//
// Two-master to one-slave Wishbone arbiter. The core's instruction port
// (iwbs_*) and data port (dwbs_*) share a single-port slave on wbm_*.
// A grant is held for the whole bus cycle (cyc) of the winning master, and
// there is always one idle cycle between grants. An optional watchdog returns
// err to the granted master when the slave stalls.
//
// Parameters
//   ROUND_ROBIN  1: alternate on simultaneous requests, 0: data port wins
//   TIMEOUT      stall limit in cycles of stb without ack/err, 0 disables
//
// Ports
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   iwbs_*                instruction master: addr/cyc/stb in, dat/ack/err out
//   dwbs_*                data master: addr/dat/sel/cyc/stb/we in,
//                         dat/ack/err out
//   wbm_*                 slave side: addr/dat/sel/cyc/stb/we out,
//                         dat/ack/err in
// -----------------------------------------------------------------------------
module mirfak_wb_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] iwbs_addr_i,
    input  logic        iwbs_cyc_i,
    input  logic        iwbs_stb_i,
    output logic [31:0] iwbs_dat_o,
    output logic        iwbs_ack_o,
    output logic        iwbs_err_o,

    input  logic [31:0] dwbs_addr_i,
    input  logic [31:0] dwbs_dat_i,
    input  logic [3:0]  dwbs_sel_i,
    input  logic        dwbs_cyc_i,
    input  logic        dwbs_stb_i,
    input  logic        dwbs_we_i,
    output logic [31:0] dwbs_dat_o,
    output logic        dwbs_ack_o,
    output logic        dwbs_err_o,

    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } state_e;

    // Watchdog is compiled out to a constant zero counter when TIMEOUT is 0.
    localparam logic        WD_EN   = (TIMEOUT > 0);
    localparam logic [15:0] WD_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

    state_e      state_q;
    state_e      state_d;
    logic        last_d_q;      // 1: data port held the most recent grant
    logic        last_d_d;
    logic [15:0] wd_cnt_q;
    logic [15:0] wd_cnt_d;

    logic        stall_s;
    logic        wd_fire_s;

    // Arbitration choice when both masters request in the same idle cycle.
    function automatic state_e pick_contended(input logic last_was_d);
        state_e pick;
        if (ROUND_ROBIN != 0) begin
            if (last_was_d) begin
                pick = ST_GNT_I;
            end else begin
                pick = ST_GNT_D;
            end
        end else begin
            pick = ST_GNT_D;
        end
        return pick;
    endfunction

    // Next-state and last-grant computation.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            ST_IDLE: begin
                if (dwbs_cyc_i && iwbs_cyc_i) begin
                    state_d = pick_contended(last_d_q);
                end else if (dwbs_cyc_i) begin
                    state_d = ST_GNT_D;
                end else if (iwbs_cyc_i) begin
                    state_d = ST_GNT_I;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT_I: begin
                if (iwbs_cyc_i) begin
                    state_d = ST_GNT_I;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT_D: begin
                if (dwbs_cyc_i) begin
                    state_d = ST_GNT_D;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Remember who won only on the transition out of IDLE.
        if (state_q == ST_IDLE && state_d == ST_GNT_D) begin
            last_d_d = 1'b1;
        end else if (state_q == ST_IDLE && state_d == ST_GNT_I) begin
            last_d_d = 1'b0;
        end else begin
            last_d_d = last_d_q;
        end
    end

    // Slave-side mux: follows the registered grant, so an async reset drops
    // cyc/stb immediately.
    always_comb begin
        wbm_addr_o = 32'd0;
        wbm_dat_o  = 32'd0;
        wbm_sel_o  = 4'd0;
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_we_o   = 1'b0;
        case (state_q)
            ST_GNT_D: begin
                wbm_addr_o = dwbs_addr_i;
                wbm_dat_o  = dwbs_dat_i;
                wbm_sel_o  = dwbs_sel_i;
                wbm_cyc_o  = dwbs_cyc_i;
                wbm_stb_o  = dwbs_stb_i;
                wbm_we_o   = dwbs_we_i;
            end
            ST_GNT_I: begin
                wbm_addr_o = iwbs_addr_i;
                wbm_dat_o  = 32'd0;
                wbm_sel_o  = 4'hF;
                wbm_cyc_o  = iwbs_cyc_i;
                wbm_stb_o  = iwbs_stb_i;
                wbm_we_o   = 1'b0;
            end
            default: begin
                wbm_addr_o = 32'd0;
                wbm_dat_o  = 32'd0;
                wbm_sel_o  = 4'd0;
                wbm_cyc_o  = 1'b0;
                wbm_stb_o  = 1'b0;
                wbm_we_o   = 1'b0;
            end
        endcase
    end

    // Watchdog: counts stalled strobe cycles; a real ack/err in the firing
    // cycle wins because it is not a stall.
    always_comb begin
        stall_s   = wbm_stb_o & ~wbm_ack_i & ~wbm_err_i;
        wd_fire_s = WD_EN & stall_s & (wd_cnt_q == WD_LAST);
        if (WD_EN && stall_s && !wd_fire_s) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
        end else begin
            wd_cnt_d = 16'd0;
        end
    end

    // Return path: read data fans out, ack/err reach only the granted master.
    always_comb begin
        iwbs_dat_o = wbm_dat_i;
        dwbs_dat_o = wbm_dat_i;
        iwbs_ack_o = 1'b0;
        iwbs_err_o = 1'b0;
        dwbs_ack_o = 1'b0;
        dwbs_err_o = 1'b0;
        if (state_q == ST_GNT_I) begin
            iwbs_ack_o = wbm_ack_i;
            iwbs_err_o = wbm_err_i | wd_fire_s;
        end else if (state_q == ST_GNT_D) begin
            dwbs_ack_o = wbm_ack_i;
            dwbs_err_o = wbm_err_i | wd_fire_s;
        end else begin
            iwbs_ack_o = 1'b0;
            dwbs_ack_o = 1'b0;
        end
    end

    // State, last-grant and watchdog registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            last_d_q <= 1'b0;
            wd_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

endmodule

// File: tb/tb_mirfak_wb_arbiter.sv
module tb_mirfak_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr, d_addr, d_dat, s_dat;
    logic [3:0]  d_sel;
    logic        i_cyc, i_stb, d_cyc, d_stb, d_we;
    logic        s_ack, s_err, f_ack, f_err;

    logic [31:0] r_idat, r_ddat, r_maddr, r_mdat;
    logic [3:0]  r_msel;
    logic        r_iack, r_ierr, r_dack, r_derr, r_mcyc, r_mstb, r_mwe;
    logic [31:0] f_idat, f_ddat, f_maddr, f_mdat;
    logic [3:0]  f_msel;
    logic        f_iack, f_ierr, f_dack, f_derr, f_mcyc, f_mstb, f_mwe;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mirfak_wb_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(8)) dut_rr (
        .clk_i(clk), .rst_i(rst),
        .iwbs_addr_i(i_addr), .iwbs_cyc_i(i_cyc), .iwbs_stb_i(i_stb),
        .iwbs_dat_o(r_idat), .iwbs_ack_o(r_iack), .iwbs_err_o(r_ierr),
        .dwbs_addr_i(d_addr), .dwbs_dat_i(d_dat), .dwbs_sel_i(d_sel),
        .dwbs_cyc_i(d_cyc), .dwbs_stb_i(d_stb), .dwbs_we_i(d_we),
        .dwbs_dat_o(r_ddat), .dwbs_ack_o(r_dack), .dwbs_err_o(r_derr),
        .wbm_addr_o(r_maddr), .wbm_dat_o(r_mdat), .wbm_sel_o(r_msel),
        .wbm_cyc_o(r_mcyc), .wbm_stb_o(r_mstb), .wbm_we_o(r_mwe),
        .wbm_dat_i(s_dat), .wbm_ack_i(s_ack), .wbm_err_i(s_err)
    );

    mirfak_wb_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(0)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .iwbs_addr_i(i_addr), .iwbs_cyc_i(i_cyc), .iwbs_stb_i(i_stb),
        .iwbs_dat_o(f_idat), .iwbs_ack_o(f_iack), .iwbs_err_o(f_ierr),
        .dwbs_addr_i(d_addr), .dwbs_dat_i(d_dat), .dwbs_sel_i(d_sel),
        .dwbs_cyc_i(d_cyc), .dwbs_stb_i(d_stb), .dwbs_we_i(d_we),
        .dwbs_dat_o(f_ddat), .dwbs_ack_o(f_dack), .dwbs_err_o(f_derr),
        .wbm_addr_o(f_maddr), .wbm_dat_o(f_mdat), .wbm_sel_o(f_msel),
        .wbm_cyc_o(f_mcyc), .wbm_stb_o(f_mstb), .wbm_we_o(f_mwe),
        .wbm_dat_i(s_dat), .wbm_ack_i(f_ack), .wbm_err_i(f_err)
    );

    task automatic clear_inputs();
        i_addr = 32'd0; i_cyc = 1'b0; i_stb = 1'b0;
        d_addr = 32'd0; d_dat = 32'd0; d_sel = 4'd0;
        d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0;
        s_dat = 32'd0; s_ack = 1'b0; s_err = 1'b0;
        f_ack = 1'b0; f_err = 1'b0;
    endtask

    // Leaves the bench at posedge+1 with both arbiters idle.
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        i_cyc = 1'b1; i_stb = 1'b1; i_addr = 32'h1000_0000;
        d_cyc = 1'b1; d_stb = 1'b1; d_addr = 32'h2000_0000;
        s_ack = 1'b1; f_ack = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if ({r_mcyc, r_mstb, r_iack, r_dack, f_mcyc, f_iack, f_dack} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {r_mcyc, r_mstb, r_iack, r_dack, f_mcyc, f_iack, f_dack});
        end
        rst = 1'b0; s_ack = 1'b0; f_ack = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (r_mcyc !== 1'b1 || r_maddr !== 32'h2000_0000) begin
            n_fail++;
            $display("FAIL reset_first_grant_rr: got cyc=%b addr=%h expected cyc=1 addr=20000000",
                     r_mcyc, r_maddr);
        end
        n_chk++;
        if (f_mcyc !== 1'b1 || f_maddr !== 32'h2000_0000) begin
            n_fail++;
            $display("FAIL reset_first_grant_fp: got cyc=%b addr=%h expected cyc=1 addr=20000000",
                     f_mcyc, f_maddr);
        end
        // Asynchronous reset mid-transaction drops the bus before any edge.
        s_ack = 1'b1;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({r_mcyc, r_mstb, r_dack, r_derr} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_async_drop: got %b expected 0000", {r_mcyc, r_mstb, r_dack, r_derr});
        end
        do_reset();
    endtask

    task automatic test_ifetch();
        do_reset();
        i_addr = 32'h8000_0000; i_cyc = 1'b1; i_stb = 1'b1;
        d_dat = 32'hFFFF_FFFF; d_we = 1'b1; d_sel = 4'h0;
        #1;
        n_chk++;
        if (r_mcyc !== 1'b0) begin
            n_fail++;
            $display("FAIL ifetch_latency: got cyc=%b expected 0", r_mcyc);
        end
        @(posedge clk); #1;
        n_chk++;
        if (r_maddr !== 32'h8000_0000 || r_msel !== 4'hF || r_mwe !== 1'b0 ||
            r_mcyc !== 1'b1 || r_mdat !== 32'd0) begin
            n_fail++;
            $display("FAIL ifetch_mux: got addr=%h sel=%h we=%b cyc=%b dat=%h expected 80000000 f 0 1 0",
                     r_maddr, r_msel, r_mwe, r_mcyc, r_mdat);
        end
        s_dat = 32'h0000_0013; s_ack = 1'b1;
        #1;
        n_chk++;
        if (r_iack !== 1'b1 || r_idat !== 32'h0000_0013 || r_dack !== 1'b0) begin
            n_fail++;
            $display("FAIL ifetch_ack: got iack=%b idat=%h dack=%b expected 1 00000013 0",
                     r_iack, r_idat, r_dack);
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_rr_contention();
        int exp_o[4] = '{2, 1, 2, 1};
        int order[4];
        int gaps[3];
        int got = 0;
        int gap = 0;
        logic i_acked = 1'b0;
        logic d_acked = 1'b0;
        do_reset();
        i_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
        for (int c = 0; c < 60 && got < 4; c++) begin
            s_ack = 1'b0;
            i_cyc = ~i_acked; i_stb = ~i_acked;
            d_cyc = ~d_acked; d_stb = ~d_acked;
            #1;
            s_ack = r_mcyc;
            #1;
            i_acked = r_iack;
            d_acked = r_dack;
            if (r_iack || r_dack) begin
                if (got > 0) gaps[got-1] = gap;
                order[got] = r_dack ? 2 : 1;
                got++;
                gap = 0;
            end else if (!r_mcyc) begin
                gap++;
            end
            @(posedge clk); #1;
        end
        clear_inputs();
        n_chk++;
        if (got !== 4) begin
            n_fail++;
            $display("FAIL rr_budget: got %0d grants expected 4", got);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_chk++;
                if (order[k] !== exp_o[k]) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got %0d expected %0d (1=I 2=D)", k, order[k], exp_o[k]);
                end
            end
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (gaps[k] !== 2) begin
                    n_fail++;
                    $display("FAIL rr_gap[%0d]: got %0d expected 2 (release + idle)", k, gaps[k]);
                end
            end
        end
    endtask

    task automatic test_fp_contention();
        int exp_o[4] = '{2, 2, 2, 1};
        int order[4];
        int got = 0;
        int nd = 0;
        logic i_acked = 1'b0;
        logic d_acked = 1'b0;
        do_reset();
        i_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
        for (int c = 0; c < 60 && got < 4; c++) begin
            f_ack = 1'b0;
            i_cyc = ~i_acked; i_stb = ~i_acked;
            d_cyc = ~d_acked && (nd < 3); d_stb = d_cyc;
            #1;
            f_ack = f_mcyc;
            #1;
            i_acked = f_iack;
            d_acked = f_dack;
            if (f_dack) nd++;
            if (f_iack || f_dack) begin
                order[got] = f_dack ? 2 : 1;
                got++;
            end
            @(posedge clk); #1;
        end
        clear_inputs();
        n_chk++;
        if (got !== 4) begin
            n_fail++;
            $display("FAIL fp_budget: got %0d grants expected 4", got);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_chk++;
                if (order[k] !== exp_o[k]) begin
                    n_fail++;
                    $display("FAIL fp_order[%0d]: got %0d expected %0d (1=I 2=D)", k, order[k], exp_o[k]);
                end
            end
        end
    endtask

    task automatic test_store();
        do_reset();
        d_addr = 32'h8000_0100; d_dat = 32'hDEAD_BEEF; d_sel = 4'b0011;
        d_we = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
        i_addr = 32'h4444_0000; i_cyc = 1'b1; i_stb = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (r_maddr !== 32'h8000_0100 || r_mdat !== 32'hDEAD_BEEF || r_msel !== 4'b0011 ||
            r_mwe !== 1'b1 || r_mcyc !== 1'b1 || r_mstb !== 1'b1) begin
            n_fail++;
            $display("FAIL store_mux: got addr=%h dat=%h sel=%b we=%b cyc=%b stb=%b expected 80000100 deadbeef 0011 1 1 1",
                     r_maddr, r_mdat, r_msel, r_mwe, r_mcyc, r_mstb);
        end
        s_ack = 1'b1;
        #1;
        n_chk++;
        if (r_dack !== 1'b1 || r_iack !== 1'b0) begin
            n_fail++;
            $display("FAIL store_ack: got dack=%b iack=%b expected 1 0", r_dack, r_iack);
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_watchdog();
        do_reset();
        d_cyc = 1'b1; d_stb = 1'b1; d_addr = 32'h0000_0040;
        @(posedge clk); #1;
        for (int k = 1; k <= 17; k++) begin
            #1;
            n_chk++;
            if (r_derr !== ((k == 8) || (k == 16)) || r_ierr !== 1'b0) begin
                n_fail++;
                $display("FAIL wd_stall cycle %0d: got derr=%b ierr=%b expected derr=%b ierr=0",
                         k, r_derr, r_ierr, (k == 8) || (k == 16));
            end
            @(posedge clk); #1;
        end
        do_reset();
        d_cyc = 1'b1; d_stb = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 8; k++) begin
            s_ack = (k == 8);
            #1;
            n_chk++;
            if (r_derr !== 1'b0 || r_dack !== (k == 8)) begin
                n_fail++;
                $display("FAIL wd_ack_wins cycle %0d: got derr=%b dack=%b expected derr=0 dack=%b",
                         k, r_derr, r_dack, k == 8);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    // Reference: owner of the bus (0 none, 1 I, 2 D), who won last, and the
    // length of the current run of stalled strobe cycles.
    task automatic test_random();
        int own = 0;
        int last = 1;
        int run = 0;
        logic g_cyc, g_stb, stall, wd;
        logic [70:0] exp_m, got_m;
        logic [3:0]  exp_r, got_r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) i_cyc = ~i_cyc;
            if ($urandom_range(0, 7) == 0) d_cyc = ~d_cyc;
            i_stb = i_cyc && ($urandom_range(0, 7) != 0);
            d_stb = d_cyc && ($urandom_range(0, 7) != 0);
            i_addr = $urandom; d_addr = $urandom; d_dat = $urandom; s_dat = $urandom;
            d_sel = 4'($urandom); d_we = 1'($urandom);
            s_ack = ($urandom_range(0, 5) == 0);
            s_err = ($urandom_range(0, 11) == 0);
            #1;
            g_cyc = (own == 2) ? d_cyc : (own == 1) ? i_cyc : 1'b0;
            g_stb = (own == 2) ? d_stb : (own == 1) ? i_stb : 1'b0;
            stall = g_stb && !s_ack && !s_err;
            wd    = stall && (run + 1 == 8);
            if (own == 2)      exp_m = {d_addr, d_dat, d_sel, d_cyc, d_stb, d_we};
            else if (own == 1) exp_m = {i_addr, 32'd0, 4'hF, i_cyc, i_stb, 1'b0};
            else               exp_m = 71'd0;
            exp_r = {(own == 1) && s_ack, (own == 1) && (s_err || wd),
                     (own == 2) && s_ack, (own == 2) && (s_err || wd)};
            got_m = {r_maddr, r_mdat, r_msel, r_mcyc, r_mstb, r_mwe};
            got_r = {r_iack, r_ierr, r_dack, r_derr};
            n_chk++;
            if (got_m !== exp_m) begin
                n_fail++;
                $display("FAIL rand_mux cycle %0d: got %h expected %h", c, got_m, exp_m);
            end
            n_chk++;
            if (got_r !== exp_r) begin
                n_fail++;
                $display("FAIL rand_resp cycle %0d: got iack,ierr,dack,derr=%b expected %b", c, got_r, exp_r);
            end
            n_chk++;
            if (r_idat !== s_dat || r_ddat !== s_dat) begin
                n_fail++;
                $display("FAIL rand_rdata cycle %0d: got %h/%h expected %h", c, r_idat, r_ddat, s_dat);
            end
            run = (stall && !wd) ? run + 1 : 0;
            if (own == 0) begin
                if (i_cyc && d_cyc) own = (last == 2) ? 1 : 2;
                else if (d_cyc)     own = 2;
                else if (i_cyc)     own = 1;
                if (own != 0) last = own;
            end else if (!g_cyc) begin
                own = 0;
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_ifetch();
        test_rr_contention();
        test_fp_contention();
        test_store();
        test_watchdog();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
